reverse_arbiter: RTL and testbench
==================================

Name: reverse_arbiter

Overview:
- Shares one bit-reversal datapath between two requester channels (A, B) using valid/ready handshakes.
- Round-robin arbitration, one-entry registered result stage, result tagged with the source ID.
- Sits between the stimulus/producer logic and any consumer of reversed words.
- Replaces two parallel combinational reversers with one scheduled, time-shared unit.

Parameters:
- WIDTH, 8, data word width in bits for requests and responses.
- CNT_W, 16, width of the grant counters (used only when REVERSE_STATS_EN is defined).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_valid  input  1  requester A has a word to reverse.
- a_data  input  WIDTH  requester A word.
- a_ready  output  1  A's word is accepted this cycle.
- b_valid  input  1  requester B has a word to reverse.
- b_data  input  WIDTH  requester B word.
- b_ready  output  1  B's word is accepted this cycle.
- rsp_valid  output  1  result register holds a valid result.
- rsp_data  output  WIDTH  bit-reversed word; bit i = source bit WIDTH-1-i.
- rsp_id  output  1  source of the result; 0 = A, 1 = B.
- rsp_ready  input  1  consumer accepts the result this cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - FSM=EMPTY, last_grant=1, so A has first priority.
  - Any in-flight result is discarded.
- FSM states:
  - EMPTY: result register free.
  - FULL: result register held.
- can_accept = (state==EMPTY) | (rsp_valid & rsp_ready).
- Grant rules, evaluated every cycle with can_accept true:
  - Only a_valid set: grant A.
  - Only b_valid set: grant B.
  - Both set: grant the requester that is not last_grant.
  - When can_accept is false: no grant.
- Ready outputs:
  - a_ready = grant_A; b_ready = grant_B.
  - At most one ready is high per cycle.
  - Ready may depend on valid; valid must not depend on ready.
- On a grant at edge N:
  - result register <= reverse(granted data), rsp_id <= granted ID, last_grant <= granted ID.
  - State becomes FULL and rsp_valid=1 after edge N, giving 1-cycle latency.
- State transitions:
  - FULL, rsp_ready=1, no grant: go to EMPTY, rsp_valid=0.
  - FULL, rsp_ready=1, new grant in the same cycle: stay FULL and load the new result. This gives back-to-back throughput of 1 word/cycle.
  - FULL, rsp_ready=0: rsp_data and rsp_id hold stable; both readies are 0.
- last_grant changes only on a grant. Idle cycles do not move priority.
- A requester whose valid is high while it is not granted keeps its data; it is not dropped.
- Reversal is purely combinational inside the datapath. Only the result register is sequential.

Optional Feature:
- Macro: REVERSE_STATS_EN.
- Defined:
  - Adds output ports cnt_a and cnt_b (CNT_W bits each).
  - Each counter increments on its requester's grant and saturates at all-ones.
  - Both reset to 0.
- Undefined:
  - The ports and counters are absent.
  - Behaviour is otherwise identical.

Decomposition:
- Package reverse_pkg holds:
  - the FSM state encoding (EMPTY=1'b0, FULL=1'b1);
  - the ID constants (ID_A=1'b0, ID_B=1'b1);
  - the default WIDTH.
- One sub-module, reverse_bits_core:
  - combinational, WIDTH-parameterised word reverser;
  - instantiated once and fed by the grant mux.
- Arbitration, FSM and result register stay in the top level.

Test Plan:
- Reset then idle:
  - Hold rst_n=0 for 2 cycles with a_valid=b_valid=0.
  - Required: rsp_valid=0, a_ready=b_ready=0, rsp_data=8'h00.
- Single A request:
  - a_valid=1, a_data=8'b00000001.
  - Required: a_ready=1 that cycle; next cycle rsp_valid=1, rsp_data=8'b10000000, rsp_id=0.
- Contention:
  - a_valid=b_valid=1 held with rsp_ready=1, a_data=8'hF0, b_data=8'h0C.
  - Required: grants alternate A,B,A,B after reset; responses alternate 8'h0F/id0 and 8'h30/id1, one per cycle.
- Backpressure:
  - Hold rsp_ready=0 for 3 cycles with a result held.
  - Required: rsp_data/rsp_id stable, a_ready=b_ready=0; release gives a grant in the same cycle.
- Reset mid-operation:
  - Assert rst_n=0 asynchronously while FULL with rsp_data=8'hA5.
  - Required: rsp_valid drops immediately without waiting for clk; after release A wins the first contention.
- REVERSE_STATS_EN build:
  - 5 A grants and 3 B grants.
  - Required: cnt_a=5, cnt_b=3.
  - With CNT_W=2 forced, 5 grants leave the counter saturated at 3.

Source files
------------

// File: rtl/reverse_pkg.sv
// Shared definitions for the time-shared bit-reversal arbiter:
// result-stage state encoding, requester IDs and the default word width.
package reverse_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

endpackage

// File: rtl/reverse_bits_core.sv
// Combinational word reverser: out bit i is in bit WIDTH-1-i.
module reverse_bits_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_word,
  output logic [WIDTH-1:0] out_word
);

  // Mirror the word bit by bit.
  always_comb begin
    // NOTE: assign a default first so no path through the block leaves the output unassigned (latch).
    out_word = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out_word[i] = in_word[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/reverse_arbiter.sv
// Round-robin arbiter sharing one bit reverser between requesters A and B,
// with a one-entry registered result stage tagged by source ID.
// Optional grant counters are compiled in with `define REVERSE_STATS_EN.
module reverse_arbiter
  import reverse_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
`ifdef REVERSE_STATS_EN
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
`endif
  input  logic             rsp_ready
);

  state_t           state;
  logic             last_grant;
  logic             can_accept;
  logic             grant_a;
  logic             grant_b;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] rev_data;

  // The result slot is free when empty or when its current result leaves this cycle.
  assign can_accept = (state == EMPTY) || (rsp_valid && rsp_ready);

  // On contention the requester that did not win last time gets the slot.
  assign grant_a = can_accept && a_valid && (!b_valid || (last_grant == ID_B));
  assign grant_b = can_accept && b_valid && (!a_valid || (last_grant == ID_A));

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  assign sel_data = grant_b ? b_data : a_data;

  reverse_bits_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .in_word  (sel_data),
    .out_word (rev_data)
  );

  // Result-stage FSM: load on grant, drain when consumed without a replacement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= ID_A;
      last_grant <= ID_B;
    end else if (grant_a || grant_b) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= FULL;
      rsp_valid  <= 1'b1;
      rsp_data   <= rev_data;
      rsp_id     <= grant_b ? ID_B : ID_A;
      last_grant <= grant_b ? ID_B : ID_A;
    end else if (rsp_valid && rsp_ready) begin
      state     <= EMPTY;
      rsp_valid <= 1'b0;
    end
  end

`ifdef REVERSE_STATS_EN
  // Saturating per-requester grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (grant_a && (cnt_a != {CNT_W{1'b1}})) cnt_a <= cnt_a + 1'b1;
      if (grant_b && (cnt_b != {CNT_W{1'b1}})) cnt_b <= cnt_b + 1'b1;
    end
  end
`else
  // Counter width has no effect when statistics are compiled out.
  if (CNT_W < 1) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_reverse_arbiter.sv
// Scoreboard bench for reverse_arbiter: a predictor derives grants and results
// from the arbitration rules, a monitor pops and compares delivered results.
module tb_reverse_arbiter;
  import reverse_pkg::*;

  localparam int W     = 8;
  localparam int CNT_W = 16;

  logic         clk;
  logic         rst_n;
  logic         a_valid, b_valid, a_ready, b_ready;
  logic [W-1:0] a_data, b_data, rsp_data;
  logic         rsp_valid, rsp_id, rsp_ready;
`ifdef REVERSE_STATS_EN
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic [1:0]       s_cnt_a, s_cnt_b;
  logic             s_a_ready, s_b_ready, s_rsp_valid, s_rsp_id;
  logic [W-1:0]     s_rsp_data;
`endif

  reverse_arbiter #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
`ifdef REVERSE_STATS_EN
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
`endif
    .rsp_ready (rsp_ready)
  );

`ifdef REVERSE_STATS_EN
  // Narrow-counter copy used only to observe saturation.
  reverse_arbiter #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (s_a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (s_b_ready),
    .rsp_valid (s_rsp_valid),
    .rsp_data  (s_rsp_data),
    .rsp_id    (s_rsp_id),
    .cnt_a     (s_cnt_a),
    .cnt_b     (s_cnt_b),
    .rsp_ready (rsp_ready)
  );
`endif

  typedef struct packed {
    logic [W-1:0] data;
    logic         id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: slot occupied, A preferred on contention, grant counts.
  bit occ;
  bit pri_a;
  bit m_free, m_ga, m_gb;
  int n_a, n_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = {<<{d}};
    return r;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Predictor: decide grants from the rules and queue the expected results.
  initial begin
    occ = 1'b0; pri_a = 1'b1; n_a = 0; n_b = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        occ = 1'b0; pri_a = 1'b1; n_a = 0; n_b = 0;
        q.delete();
      end else begin
        check("rsp_valid_model", rsp_valid, occ);
        m_free = !occ || rsp_ready;
        m_ga   = m_free && a_valid && (!b_valid || pri_a);
        m_gb   = m_free && b_valid && (!a_valid || !pri_a);
        check("a_ready_model", a_ready, m_ga);
        check("b_ready_model", b_ready, m_gb);
        if (m_ga) begin
          q.push_back('{data: rev(a_data), id: ID_A});
          pri_a = 1'b0;
          n_a++;
        end
        if (m_gb) begin
          q.push_back('{data: rev(b_data), id: ID_B});
          pri_a = 1'b1;
          n_b++;
        end
        occ = m_ga || m_gb || (occ && !rsp_ready);
      end
    end
  end

  // Monitor: every consumed result must match the oldest expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 1'b0);
        end else begin
          e = q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_id", rsp_id, e.id);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] held_d;
    logic         held_id;
    logic         ga, gb;
    int           wait_cnt;

    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    a_data = '0; b_data = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_a_ready", a_ready, 1'b0);
    check("reset_b_ready", b_ready, 1'b0);
    check("reset_rsp_data", rsp_data, 8'h00);
    rst_n = 1'b1;
    step();

    // Contention: A first after reset, then strict alternation.
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hF0; b_data = 8'h0C;
    #1;
    check("contention_first_a", a_ready, 1'b1);
    repeat (6) step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    step();

    // Single A request.
    a_valid = 1'b1; a_data = 8'b0000_0001;
    #1;
    check("single_a_ready", a_ready, 1'b1);
    step();
    a_valid = 1'b0;
    check("single_rsp_valid", rsp_valid, 1'b1);
    check("single_rsp_data", rsp_data, 8'b1000_0000);
    check("single_rsp_id", rsp_id, ID_A);
    step();

    // Backpressure: result held for 3 cycles, both requesters waiting.
    rsp_ready = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = W'($urandom); b_data = W'($urandom);
    step();
    held_d = rsp_data; held_id = rsp_id;
    for (int i = 0; i < 3; i++) begin
      check("bp_a_ready", a_ready, 1'b0);
      check("bp_b_ready", b_ready, 1'b0);
      check("bp_rsp_data", rsp_data, held_d);
      check("bp_rsp_id", rsp_id, held_id);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_grant", a_ready || b_ready, 1'b1);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    step();

    // Asynchronous reset while a result is held.
    rsp_ready = 1'b0; a_valid = 1'b1; a_data = 8'hA5;
    step();
    a_valid = 1'b0;
    check("pre_reset_rsp_data", rsp_data, 8'hA5);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_rsp_valid", rsp_valid, 1'b0);
    check("async_reset_rsp_data", rsp_data, 8'h00);
    step();
    step();
    rst_n = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1; rsp_ready = 1'b1;
    a_data = 8'h3C; b_data = 8'h81;
    #1;
    check("post_reset_a_first", a_ready, 1'b1);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();

    // Randomized traffic; a waiting requester keeps its word until granted.
    for (int i = 0; i < 400; i++) begin
      if (!a_valid || ga) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_data  = W'($urandom);
      end
      if (!b_valid || gb) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_data  = W'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      ga = a_ready;
      gb = b_ready;
      step();
    end

    // Drain.
    a_valid = 1'b0; b_valid = 1'b0; rsp_ready = 1'b1;
    wait_cnt = 0;
    while ((q.size() != 0 || rsp_valid) && wait_cnt < 20) begin
      step();
      wait_cnt++;
    end
    check("drain_queue_empty", q.size(), 0);
    check("drain_rsp_valid", rsp_valid, 1'b0);

`ifdef REVERSE_STATS_EN
    check("cnt_a", cnt_a, n_a);
    check("cnt_b", cnt_b, n_b);
    check("sat_cnt_a", s_cnt_a, (n_a > 3) ? 3 : n_a);
    check("sat_cnt_b", s_cnt_b, (n_b > 3) ? 3 : n_b);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
